uart_frame_parser: RTL

//  Consumes the byte stream from the UART receiver (rx_dv/rx_byte pulse pairs) and extracts

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_byte_timer.sv | 37 +++
 rtl/uart_frame_parser.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command-frame parser.
package uart_pkg;

  typedef enum logic [2:0] {
    HUNT,
    CMD,
    LEN,
    PAYLOAD,
    CHECK
  } parser_state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_LEN,
    ERR_CHK,
    ERR_TIMEOUT
  } frame_err_t;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte idle timer: counts idle clocks while enabled, pulses expire on the
// cycle the count sits at TIMEOUT_CLKS-1 with no clear pending.
module uart_byte_timer #(
  parameter  int TIMEOUT_CLKS = 21700,
  localparam int CW           = $clog2(TIMEOUT_CLKS) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CLKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A clear on the expiry cycle wins, so a late byte is never aborted.
  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (clear || !enable) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      expire = 1'b1;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Extracts SYNC/CMD/LEN/PAYLOAD/CHK frames from the UART byte stream, streams
// payload bytes and flags each frame good or bad; all outputs registered.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter  logic [7:0] SYNC_BYTE    = DEF_SYNC_BYTE,
  parameter  int         MAX_LEN      = 16,
  parameter  int         TIMEOUT_CLKS = 21700,
  localparam int         IDX_W        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_rx_dv,
  input  logic [7:0]       i_rx_byte,
  output logic [7:0]       o_cmd,
  output logic [7:0]       o_len,
  output logic             o_data_valid,
  output logic [7:0]       o_data_byte,
  output logic [IDX_W-1:0] o_data_idx,
  output logic             o_frame_ok,
  output logic             o_frame_err,
  output logic [1:0]       o_err_code
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  parser_state_t    state_q, state_d;
  logic [7:0]       chk_q, chk_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       len_q, len_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             data_valid_q, data_valid_d;
  logic [7:0]       data_byte_q, data_byte_d;
  logic [IDX_W-1:0] data_idx_q, data_idx_d;
  logic             frame_ok_q, frame_ok_d;
  logic             frame_err_q, frame_err_d;
  frame_err_t       err_code_q, err_code_d;

  logic tmr_expire;
  logic len_too_long;
  logic last_payload;

  uart_byte_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (i_rx_dv),
    .enable (state_q != HUNT),
    .expire (tmr_expire)
  );

  assign len_too_long = i_rx_byte > MAX_LEN_B;
  assign last_payload = 8'(idx_q) == (len_q - 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_rx_dv) begin
      unique case (state_q)
        HUNT:    if (i_rx_byte == SYNC_BYTE) state_d = CMD;
        CMD:     state_d = LEN;
        LEN:     state_d = len_too_long      ? HUNT :
                           (i_rx_byte == '0) ? CHECK : PAYLOAD;
        PAYLOAD: if (last_payload) state_d = CHECK;
        CHECK:   state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end else if (tmr_expire) begin
      state_d = HUNT;
    end
  end

  always_comb begin
    chk_d        = chk_q;
    cmd_d        = cmd_q;
    len_d        = len_q;
    idx_d        = idx_q;
    data_valid_d = 1'b0;
    data_byte_d  = data_byte_q;
    data_idx_d   = data_idx_q;
    frame_ok_d   = 1'b0;
    frame_err_d  = 1'b0;
    err_code_d   = err_code_q;
    if (i_rx_dv) begin
      unique case (state_q)
        HUNT: if (i_rx_byte == SYNC_BYTE) begin
          chk_d = '0;
          idx_d = '0;
        end
        CMD: begin
          cmd_d = i_rx_byte;
          chk_d = i_rx_byte;
        end
        LEN: begin
          len_d = i_rx_byte;
          chk_d = chk_q ^ i_rx_byte;
          idx_d = '0;
          if (len_too_long) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
          end
        end
        PAYLOAD: begin
          data_valid_d = 1'b1;
          data_byte_d  = i_rx_byte;
          data_idx_d   = idx_q;
          chk_d        = chk_q ^ i_rx_byte;
          idx_d        = idx_q + 1'b1;
        end
        CHECK: begin
          if (i_rx_byte == chk_q) begin
            frame_ok_d = 1'b1;
            err_code_d = ERR_NONE;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHK;
          end
        end
        default: ;
      endcase
    end else if (tmr_expire) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_q        <= '0;
      cmd_q        <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      data_valid_q <= 1'b0;
      data_byte_q  <= '0;
      data_idx_q   <= '0;
      frame_ok_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      chk_q        <= chk_d;
      cmd_q        <= cmd_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      data_valid_q <= data_valid_d;
      data_byte_q  <= data_byte_d;
      data_idx_q   <= data_idx_d;
      frame_ok_q   <= frame_ok_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign o_cmd        = cmd_q;
  assign o_len        = len_q;
  assign o_data_valid = data_valid_q;
  assign o_data_byte  = data_byte_q;
  assign o_data_idx   = data_idx_q;
  assign o_frame_ok   = frame_ok_q;
  assign o_frame_err  = frame_err_q;
  assign o_err_code   = err_code_q;

endmodule
